// File: rtl/csr_pkg.sv
// csr_pkg: shared types for the Zicsr read-modify-write unit.
// Optional build macro CSR_COUNTINHIBIT_EN enables mcountinhibit (0x320).
package csr_pkg;

    localparam int DATA_W = 32;

    // Read-only CSRs live in the 0xC00..0xFFF quadrant.
    localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

    typedef enum logic [11:0] {
        CSR_MCOUNTINHIBIT = 12'h320,
        CSR_MSCRATCH      = 12'h340,
        CSR_MCYCLE        = 12'hB00,
        CSR_MINSTRET      = 12'hB02,
        CSR_MCYCLEH       = 12'hB80,
        CSR_MINSTRETH     = 12'hB82,
        CSR_CYCLE         = 12'hC00,
        CSR_INSTRET       = 12'hC02,
        CSR_CYCLEH        = 12'hC80,
        CSR_INSTRETH      = 12'hC82
    } csr_address_t;

    typedef enum logic [2:0] {
        OP_ILL0 = 3'b000,
        OP_RW   = 3'b001,
        OP_RS   = 3'b010,
        OP_RC   = 3'b011,
        OP_ILL4 = 3'b100,
        OP_RWI  = 3'b101,
        OP_RSI  = 3'b110,
        OP_RCI  = 3'b111
    } csr_op_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } rmw_state_t;

    // Request as latched on acceptance.
    typedef struct packed {
        csr_op_t            op;
        logic [11:0]        addr;
        logic [4:0]         rs1_idx;
        logic [DATA_W-1:0]  rs1_data;
    } csr_req_t;

    // New CSR value for a given op; the immediate forms share the low two bits.
    function automatic logic [DATA_W-1:0] rmw_apply(input csr_op_t op,
                                                    input logic [DATA_W-1:0] old,
                                                    input logic [DATA_W-1:0] src);
        logic [DATA_W-1:0] res;
        res = old;
        case (op)
            OP_RW, OP_RWI: res = src;
            OP_RS, OP_RSI: res = old | src;
            OP_RC, OP_RCI: res = old & ~src;
            default:       res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: CNT_W-bit free-running counter exposed as two 32-bit halves.
// A write to either half replaces that half and suppresses the increment
// for the whole counter in the same cycle.
import csr_pkg::*;

module csr_counter64 #(
    parameter int CNT_W = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        inhibit,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    logic [CNT_W-1:0] cnt;
    logic [63:0]      cnt_ext;

    // Write has priority over increment; wrap is the natural adder overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) cnt[31:0]       <= wdata;
            if (wr_hi) cnt[CNT_W-1:32] <= wdata[CNT_W-33:0];
        end else if (inc && !inhibit) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Bits above CNT_W read as zero.
    assign cnt_ext = 64'(cnt);
    assign lo      = cnt_ext[31:0];
    assign hi      = cnt_ext[63:32];

endmodule

// File: rtl/csr_rmw_unit.sv
// csr_rmw_unit: sequenced Zicsr read-modify-write for mscratch, mcycle(h),
// minstret(h) and their user read-only shadows.
// Optional build macro CSR_COUNTINHIBIT_EN adds mcountinhibit at 0x320.
import csr_pkg::*;

module csr_rmw_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [2:0]      i_funct3,
    input  logic [11:0]     i_csr_addr,
    input  logic [4:0]      i_rs1_idx,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic            i_instret_inc,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [XLEN-1:0] o_rsp_data,
    output logic            o_rsp_illegal
);

    rmw_state_t  state;
    csr_req_t    req_q;
    logic [31:0] old_q;
    logic [31:0] wval_q;
    logic        commit_q;
    logic        illegal_q;

    logic [31:0] mscratch;
    logic [31:0] cyc_lo, cyc_hi, ins_lo, ins_hi;
    logic        inh_cy, inh_ir;

    logic [31:0] rd_data;
    logic        addr_known;
    logic [31:0] src;
    logic        op_ok;
    logic        wr_en;
    logic        illegal;
    logic        do_write;

    // Read mux over the latched address; unknown addresses flag illegal.
    always_comb begin
        rd_data    = '0;
        addr_known = 1'b1;
        case (req_q.addr)
            CSR_MSCRATCH:               rd_data = mscratch;
            CSR_MCYCLE,   CSR_CYCLE:    rd_data = cyc_lo;
            CSR_MCYCLEH,  CSR_CYCLEH:   rd_data = cyc_hi;
            CSR_MINSTRET, CSR_INSTRET:  rd_data = ins_lo;
            CSR_MINSTRETH, CSR_INSTRETH: rd_data = ins_hi;
`ifdef CSR_COUNTINHIBIT_EN
            CSR_MCOUNTINHIBIT:          rd_data = {29'd0, inh_ir, 1'b0, inh_cy};
`endif
            default:                    addr_known = 1'b0;
        endcase
    end

    // Operand selection, write intent and legality for the latched request.
    assign src     = req_q.op[2] ? {27'd0, req_q.rs1_idx} : req_q.rs1_data;
    assign op_ok   = (req_q.op[1:0] != 2'b00);
    assign wr_en   = (req_q.op[1:0] == 2'b01) || (req_q.rs1_idx != 5'd0);
    assign illegal = !addr_known || !op_ok ||
                     (wr_en && (req_q.addr[11:10] == CSR_RO_PREFIX));

    // Request sequencer: accept, read, commit, hold response until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            req_q         <= '0;
            old_q         <= '0;
            wval_q        <= '0;
            commit_q      <= 1'b0;
            illegal_q     <= 1'b0;
            o_req_ready   <= 1'b1;
            o_rsp_valid   <= 1'b0;
            o_rsp_data    <= '0;
            o_rsp_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        req_q <= '{op:       csr_op_t'(i_funct3),
                                   addr:     i_csr_addr,
                                   rs1_idx:  i_rs1_idx,
                                   rs1_data: i_rs1_data};
                        o_req_ready <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    old_q     <= rd_data;
                    wval_q    <= rmw_apply(req_q.op, rd_data, src);
                    commit_q  <= wr_en && !illegal;
                    illegal_q <= illegal;
                    state     <= WRITE;
                end
                WRITE: begin
                    o_rsp_valid   <= 1'b1;
                    o_rsp_data    <= illegal_q ? '0 : old_q;
                    o_rsp_illegal <= illegal_q;
                    state         <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Writes land at the end of the WRITE cycle using the value computed in READ.
    assign do_write = (state == WRITE) && commit_q;

    // mscratch storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mscratch <= '0;
        end else if (do_write && (req_q.addr == CSR_MSCRATCH)) begin
            mscratch <= wval_q;
        end
    end

`ifdef CSR_COUNTINHIBIT_EN
    // mcountinhibit: only CY (bit 0) and IR (bit 2) are implemented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inh_cy <= 1'b0;
            inh_ir <= 1'b0;
        end else if (do_write && (req_q.addr == CSR_MCOUNTINHIBIT)) begin
            inh_cy <= wval_q[0];
            inh_ir <= wval_q[2];
        end
    end
`else
    assign inh_cy = 1'b0;
    assign inh_ir = 1'b0;
`endif

    csr_counter64 #(.CNT_W(CNT_W)) u_mcycle (
        .clk     (clk),
        .reset   (reset),
        .inc     (1'b1),
        .inhibit (inh_cy),
        .wr_lo   (do_write && (req_q.addr == CSR_MCYCLE)),
        .wr_hi   (do_write && (req_q.addr == CSR_MCYCLEH)),
        .wdata   (wval_q),
        .lo      (cyc_lo),
        .hi      (cyc_hi)
    );

    csr_counter64 #(.CNT_W(CNT_W)) u_minstret (
        .clk     (clk),
        .reset   (reset),
        .inc     (i_instret_inc),
        .inhibit (inh_ir),
        .wr_lo   (do_write && (req_q.addr == CSR_MINSTRET)),
        .wr_hi   (do_write && (req_q.addr == CSR_MINSTRETH)),
        .wdata   (wval_q),
        .lo      (ins_lo),
        .hi      (ins_hi)
    );

endmodule
